// File: rtl/cycle_seq_pkg.sv
// rtl/cycle_seq_pkg.sv - shared state encodings and default counter width for the cycle sequencer
package cycle_seq_pkg;

   localparam int CNT_W_DEFAULT = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALTED = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_FETCH  = ST_FETCH,
      S_DECODE = ST_DECODE,
      S_EXEC   = ST_EXEC,
      S_MEM    = ST_MEM,
      S_WB     = ST_WB,
      S_HALTED = ST_HALTED
   } state_t;

endpackage

// File: rtl/cycle_sequencer_instr_counter.sv
// rtl/cycle_sequencer_instr_counter.sv - wrapping retired-instruction counter
module instr_counter #(
   parameter int CNT_W = cycle_seq_pkg::CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Natural binary overflow gives the wrap from all-ones back to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - Moore instruction phase sequencer with retired-instruction count
// Optional MEM phase with mem_ready wait is built when CYCLE_SEQ_MEM_PHASE_EN is defined.
module cycle_sequencer #(
   parameter int CNT_W = cycle_seq_pkg::CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             stall,
   input  logic             halt,
   input  logic             mem_ready,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   import cycle_seq_pkg::*;

   state_t state;
   state_t state_nx;
   logic   halt_pend;
   logic   retire;

   // A halt seen in the same cycle as HALTED entry is consumed by that entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         halt_pend <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx == S_HALTED && state != S_HALTED) begin
            halt_pend <= 1'b0;
         end else if (halt) begin
            halt_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      fetch_en  = 1'b0;
      decode_en = 1'b0;
      exec_en   = 1'b0;
      mem_en    = 1'b0;
      wb_en     = 1'b0;
      busy      = 1'b0;
      halted    = 1'b0;
      retire    = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nx = S_FETCH;
         end
         S_FETCH: begin
            fetch_en = 1'b1;
            busy     = 1'b1;
            if (!stall) state_nx = S_DECODE;
         end
         S_DECODE: begin
            decode_en = 1'b1;
            busy      = 1'b1;
            if (!stall) state_nx = S_EXEC;
         end
         S_EXEC: begin
            exec_en = 1'b1;
            busy    = 1'b1;
`ifdef CYCLE_SEQ_MEM_PHASE_EN
            if (!stall) state_nx = S_MEM;
`else
            if (!stall) state_nx = S_WB;
`endif
         end
`ifdef CYCLE_SEQ_MEM_PHASE_EN
         S_MEM: begin
            mem_en = 1'b1;
            busy   = 1'b1;
            if (!stall && mem_ready) state_nx = S_WB;
         end
`endif
         S_WB: begin
            wb_en = 1'b1;
            busy  = 1'b1;
            if (!stall) begin
               retire = 1'b1;
               if (halt_pend || halt) begin
                  state_nx = S_HALTED;
               end else if (run) begin
                  state_nx = S_FETCH;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         S_HALTED: begin
            halted = 1'b1;
            // Leaving only on run=0 forces a fresh run edge to restart.
            if (!run) state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

`ifndef CYCLE_SEQ_MEM_PHASE_EN
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   instr_counter #(
      .CNT_W (CNT_W)
   ) u_instr_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire),
      .count (instr_cnt)
   );

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - self-checking bench for cycle_sequencer (directed scenarios plus randomized model check)
module tb_cycle_sequencer;

   localparam int CW = 4;
`ifdef CYCLE_SEQ_MEM_PHASE_EN
   localparam bit MEMEN = 1'b1;
`else
   localparam bit MEMEN = 1'b0;
`endif
   localparam int L = MEMEN ? 5 : 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic          stall = 1'b0;
   logic          halt = 1'b0;
   logic          mem_ready = 1'b0;
   logic          fetch_en, decode_en, exec_en, mem_en, wb_en, busy, halted;
   logic [CW-1:0] instr_cnt;
   logic [4:0]    en;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: mode 0 idle, 1 in instruction, 2 halted; m_p = phase index within instruction
   int m_mode = 0;
   int m_p    = 0;
   int m_cnt  = 0;
   bit m_pend = 1'b0;

   logic [4:0] seq [5];

   cycle_sequencer #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .stall     (stall),
      .halt      (halt),
      .mem_ready (mem_ready),
      .fetch_en  (fetch_en),
      .decode_en (decode_en),
      .exec_en   (exec_en),
      .mem_en    (mem_en),
      .wb_en     (wb_en),
      .busy      (busy),
      .halted    (halted),
      .instr_cnt (instr_cnt)
   );

   assign en = {fetch_en, decode_en, exec_en, mem_en, wb_en};

   always #5 clk = ~clk;

   task automatic model_tick();
      bit np;
      np = m_pend | halt;
      if (rst) begin
         m_mode = 0;
         m_p    = 0;
         m_pend = 1'b0;
         m_cnt  = 0;
         return;
      end
      case (m_mode)
         0: if (run) begin
            m_mode = 1;
            m_p    = 0;
         end
         1: if (!stall) begin
            if (m_p == L - 1) begin
               m_cnt = (m_cnt + 1) % (1 << CW);
               if (np) begin
                  m_mode = 2;
                  np     = 1'b0;
               end else if (run) begin
                  m_p = 0;
               end else begin
                  m_mode = 0;
               end
            end else if (!(MEMEN && m_p == 3 && !mem_ready)) begin
               m_p = m_p + 1;
            end
         end
         default: if (!run) m_mode = 0;
      endcase
      m_pend = np;
   endtask

   function automatic logic [4:0] model_en();
      if (m_mode != 1) return 5'b00000;
      if (m_p == L - 1) return 5'b00001;
      return 5'b10000 >> m_p;
   endfunction

   task automatic step();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; stall = 1'b0; halt = 1'b0; mem_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; halt = 1'b1; mem_ready = 1'b1;
      step();
      step();
      n_cmp++;
      if ({en, busy, halted} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want 0000000", {en, busy, halted});
      end
      n_cmp++;
      if (instr_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_cnt: got %0d want 0", instr_cnt);
      end
      rst = 1'b0; run = 1'b0; halt = 1'b0;
      step();
      n_cmp++;
      if ({en, busy, halted} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_idle_hold: got %b want 0000000", {en, busy, halted});
      end
   endtask

   task automatic test_pipeline();
      do_reset();
      run = 1'b1; mem_ready = 1'b1;
      for (int c = 1; c <= 2 * L; c++) begin
         step();
         n_cmp++;
         if (en !== seq[(c - 1) % L] || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pipeline_cycle%0d: got en=%b busy=%b want en=%b busy=1", c, en, busy, seq[(c - 1) % L]);
         end
      end
      step();
      n_cmp++;
      if (instr_cnt !== 4'd2 || fetch_en !== 1'b1) begin
         n_bad++;
         $display("FAIL pipeline_cnt: got cnt=%0d fetch=%b want cnt=2 fetch=1", instr_cnt, fetch_en);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      run = 1'b1; mem_ready = 1'b0;
`ifdef CYCLE_SEQ_MEM_PHASE_EN
      repeat (4) step();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (mem_en !== 1'b1 || wb_en !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_wait%0d: got mem=%b wb=%b want mem=1 wb=0", i, mem_en, wb_en);
         end
         mem_ready = (i == 3);
         step();
      end
      mem_ready = 1'b0;
      n_cmp++;
      if (wb_en !== 1'b1 || instr_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL mem_wait_wb: got wb=%b cnt=%0d want wb=1 cnt=0", wb_en, instr_cnt);
      end
      step();
      n_cmp++;
      if (instr_cnt !== 4'd1) begin
         n_bad++;
         $display("FAIL mem_wait_cnt: got %0d want 1", instr_cnt);
      end
`else
      for (int c = 1; c <= 2 * L; c++) begin
         step();
         n_cmp++;
         if (en !== seq[(c - 1) % L]) begin
            n_bad++;
            $display("FAIL nomem_cycle%0d: got %b want %b", c, en, seq[(c - 1) % L]);
         end
      end
`endif
   endtask

   task automatic test_stall();
      do_reset();
      run = 1'b1; mem_ready = 1'b1;
      step();
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (decode_en !== 1'b1 || instr_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL stall_decode%0d: got dec=%b cnt=%0d want dec=1 cnt=0", i, decode_en, instr_cnt);
         end
         if (i == 2) stall = 1'b0;
         step();
      end
      n_cmp++;
      if (exec_en !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_exec: got %b want 1", exec_en);
      end
      repeat (L - 3) step();
      n_cmp++;
      if (wb_en !== 1'b1 || instr_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL stall_wb: got wb=%b cnt=%0d want wb=1 cnt=0", wb_en, instr_cnt);
      end
      step();
      n_cmp++;
      if (instr_cnt !== 4'd1) begin
         n_bad++;
         $display("FAIL stall_cnt: got %0d want 1", instr_cnt);
      end
   endtask

   task automatic test_halt();
      do_reset();
      run = 1'b1; mem_ready = 1'b1;
      step();
      halt = 1'b1;
      step();
      halt = 1'b0;
      repeat (L - 2) step();
      n_cmp++;
      if (wb_en !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_wb: got %b want 1", wb_en);
      end
      step();
      n_cmp++;
      if ({halted, busy, en} !== 7'b1000000 || instr_cnt !== 4'd1) begin
         n_bad++;
         $display("FAIL halt_enter: got hb_en=%b cnt=%0d want 1000000 cnt=1", {halted, busy, en}, instr_cnt);
      end
      repeat (3) step();
      n_cmp++;
      if (halted !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_hold: got halted=%b busy=%b want 1 0", halted, busy);
      end
      run = 1'b0;
      step();
      n_cmp++;
      if (halted !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_release: got halted=%b busy=%b want 0 0", halted, busy);
      end
      run = 1'b1;
      step();
      n_cmp++;
      if (fetch_en !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_restart: got %b want 1", fetch_en);
      end
      repeat (L) step();
      n_cmp++;
      if (fetch_en !== 1'b1 || halted !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_pend_clear: got fetch=%b halted=%b want 1 0", fetch_en, halted);
      end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      run = 1'b1; mem_ready = 1'b1;
      repeat (16 * L) step();
      n_cmp++;
      if (instr_cnt !== 4'd15 || wb_en !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_pre: got cnt=%0d wb=%b want 15 1", instr_cnt, wb_en);
      end
      step();
      n_cmp++;
      if (instr_cnt !== 4'd0 || fetch_en !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_zero: got cnt=%0d fetch=%b want 0 1", instr_cnt, fetch_en);
      end
      repeat (L) step();
      mem_ready = 1'b0;
      repeat (L - 2) step();
      if (MEMEN) repeat (2) step();
      n_cmp++;
      if (instr_cnt !== 4'd1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_inst_pre: got cnt=%0d busy=%b want 1 1", instr_cnt, busy);
      end
      rst = 1'b1;
      step();
      n_cmp++;
      if ({en, busy, halted} !== 7'b0 || instr_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL mid_inst_reset: got %b cnt=%0d want 0000000 cnt=0", {en, busy, halted}, instr_cnt);
      end
      rst = 1'b0; run = 1'b0;
   endtask

   task automatic test_random();
      logic [10:0] want;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst       = ($urandom % 64) == 0;
         run       = ($urandom % 8) != 0;
         stall     = ($urandom % 5) == 0;
         halt      = ($urandom % 25) == 0;
         mem_ready = $urandom % 2;
         step();
         want = {model_en(), m_mode == 1, m_mode == 2, m_cnt[CW-1:0]};
         n_cmp++;
         if ({en, busy, halted, instr_cnt} !== want) begin
            n_bad++;
            $display("FAIL random_cycle%0d: got en=%b busy=%b halted=%b cnt=%0d want en=%b busy=%b halted=%b cnt=%0d",
                     i, en, busy, halted, instr_cnt, want[10:6], want[5], want[4], want[3:0]);
         end
         n_cmp++;
         if ($countones(en) > 1 || (!MEMEN && mem_en !== 1'b0)) begin
            n_bad++;
            $display("FAIL random_onehot%0d: got en=%b want at most one bit", i, en);
         end
      end
   endtask

   initial begin
      if (MEMEN) begin
         seq[0] = 5'b10000; seq[1] = 5'b01000; seq[2] = 5'b00100; seq[3] = 5'b00010; seq[4] = 5'b00001;
      end else begin
         seq[0] = 5'b10000; seq[1] = 5'b01000; seq[2] = 5'b00100; seq[3] = 5'b00001; seq[4] = 5'b00000;
      end
      test_reset();
      test_pipeline();
      test_mem_wait();
      test_stall();
      test_halt();
      test_wrap_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
